// File: rtl/fmc_adc_pattern_gen_if.sv
// Configuration and sample-stream bundle of the FMC ADC pattern generator.
// The slave side is the generator; the master side is whoever configures it and consumes samples.
interface fmc_adc_pattern_gen_if #(
  parameter int g_NB_CHANNELS     = 4,
  parameter int g_DATA_WIDTH      = 14,
  parameter int g_FRAME_DIV_WIDTH = 4
);
  logic                                   enable_i;
  logic [1:0]                             mode_i;
  logic [g_FRAME_DIV_WIDTH-1:0]           frame_div_i;
  logic [g_DATA_WIDTH-1:0]                const_i;
  logic [g_DATA_WIDTH-1:0]                ramp_step_i;
  logic [15:0]                            burst_len_i;

  logic                                   frame_o;
  logic                                   valid_o;
  logic [g_NB_CHANNELS*g_DATA_WIDTH-1:0]  data_o;
  logic                                   busy_o;
  logic                                   done_o;
  logic [15:0]                            sample_cnt_o;

  modport master (
    output enable_i, mode_i, frame_div_i, const_i, ramp_step_i, burst_len_i,
    input  frame_o, valid_o, data_o, busy_o, done_o, sample_cnt_o
  );

  modport slave (
    input  enable_i, mode_i, frame_div_i, const_i, ramp_step_i, burst_len_i,
    output frame_o, valid_o, data_o, busy_o, done_o, sample_cnt_o
  );
endinterface

// File: rtl/fmc_adc_pattern_gen.sv
// Multi-channel ADC pattern/frame generator: constant, ramp, LFSR and alternating
// data with a programmable frame period and optional bounded bursts.
module fmc_adc_pattern_gen #(
  parameter int g_NB_CHANNELS     = 4,
  parameter int g_DATA_WIDTH      = 14,
  parameter int g_FRAME_DIV_WIDTH = 4
) (
  input  logic                clk_sys_i,
  input  logic                rst_sys_i,
  fmc_adc_pattern_gen_if.slave bus
);

  localparam int          W           = g_DATA_WIDTH;
  localparam int          DW          = g_NB_CHANNELS * g_DATA_WIDTH;
  localparam int          FW          = g_FRAME_DIV_WIDTH;
  localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] c_LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  typedef enum logic [1:0] {
    MODE_CONST = 2'b00,
    MODE_RAMP  = 2'b01,
    MODE_LFSR  = 2'b10,
    MODE_ALT   = 2'b11
  } mode_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? c_LFSR_TAPS : 16'h0000);
  endfunction

  state_t          state_q, state_d;
  mode_t           mode_q, mode_d;
  logic [FW-1:0]   div_q, div_d;
  logic [FW-1:0]   div_cnt_q, div_cnt_d;
  logic [W-1:0]    const_q, const_d;
  logic [W-1:0]    step_q, step_d;
  logic [W-1:0]    ramp_q, ramp_d;
  logic [15:0]     burst_q, burst_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [15:0]     sample_cnt_q, sample_cnt_d;
  logic            low_seen_q, low_seen_d;
  logic            frame_q, frame_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   data_q, data_d;

  // Operand selection: the start edge works on live inputs, later edges on the latched copy.
  logic            start;
  logic            emit;
  mode_t           cur_mode;
  logic [W-1:0]    cur_const;
  logic [W-1:0]    cur_step;
  logic [W-1:0]    cur_ramp;
  logic [15:0]     cur_lfsr;
  logic [15:0]     cur_burst;
  logic            cur_odd;
  logic [DW-1:0]   sample_data;
  logic [W-1:0]    chan;

  always_comb begin
    start = (state_q == ST_IDLE) && bus.enable_i && low_seen_q;
    if (start) begin
      cur_mode  = mode_t'(bus.mode_i);
      cur_const = bus.const_i;
      cur_step  = bus.ramp_step_i;
      cur_ramp  = bus.const_i;
      cur_lfsr  = c_LFSR_SEED;
      cur_burst = bus.burst_len_i;
      cur_odd   = 1'b0;
    end else begin
      cur_mode  = mode_q;
      cur_const = const_q;
      cur_step  = step_q;
      cur_ramp  = ramp_q;
      cur_lfsr  = lfsr_q;
      cur_burst = burst_q;
      cur_odd   = sample_cnt_q[0];
    end
  end

  // ramp_q already holds const + n*step, so each channel only adds its index.
  always_comb begin
    sample_data = '0;
    chan        = '0;
    for (int k = 0; k < g_NB_CHANNELS; k++) begin
      unique case (cur_mode)
        MODE_CONST: chan = cur_const;
        MODE_RAMP:  chan = cur_ramp + W'(k);
        MODE_LFSR:  chan = cur_lfsr[W-1:0] ^ W'(k);
        default:    chan = cur_odd ? ~cur_const : cur_const;
      endcase
      sample_data[k*W +: W] = chan;
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no branch can leave one unassigned and infer a latch.
    state_d      = state_q;
    mode_d       = mode_q;
    div_d        = div_q;
    div_cnt_d    = div_cnt_q;
    const_d      = const_q;
    step_d       = step_q;
    ramp_d       = ramp_q;
    burst_d      = burst_q;
    lfsr_d       = lfsr_q;
    sample_cnt_d = sample_cnt_q;
    low_seen_d   = low_seen_q;
    data_d       = data_q;
    busy_d       = busy_q;
    frame_d      = 1'b0;
    done_d       = 1'b0;
    emit         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (!bus.enable_i) low_seen_d = 1'b1;
        if (start) begin
          state_d      = ST_RUN;
          busy_d       = 1'b1;
          low_seen_d   = 1'b0;
          mode_d       = mode_t'(bus.mode_i);
          div_d        = bus.frame_div_i;
          const_d      = bus.const_i;
          step_d       = bus.ramp_step_i;
          burst_d      = bus.burst_len_i;
          ramp_d       = bus.const_i;
          lfsr_d       = c_LFSR_SEED;
          div_cnt_d    = '0;
          sample_cnt_d = '0;
          emit         = (bus.frame_div_i == '0);
        end
      end
      ST_RUN: begin
        if (!bus.enable_i) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          low_seen_d = 1'b1;
        end else begin
          div_cnt_d = (div_cnt_q == div_q) ? '0 : div_cnt_q + FW'(1);
          emit      = (div_cnt_d == div_q);
        end
      end
      ST_DONE: begin
        // Enable is deliberately not looked at here, so a low in this cycle does not arm a restart.
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (emit) begin
      frame_d      = 1'b1;
      data_d       = sample_data;
      sample_cnt_d = sample_cnt_d + 16'd1;
      ramp_d       = cur_ramp + cur_step;
      lfsr_d       = lfsr_next(cur_lfsr);
      if ((cur_burst != 16'd0) && (sample_cnt_d == cur_burst)) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_CONST;
      div_q        <= '0;
      div_cnt_q    <= '0;
      const_q      <= '0;
      step_q       <= '0;
      ramp_q       <= '0;
      burst_q      <= '0;
      lfsr_q       <= c_LFSR_SEED;
      sample_cnt_q <= '0;
      low_seen_q   <= 1'b1;
      frame_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      data_q       <= '0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge value of every other one.
      state_q      <= state_d;
      mode_q       <= mode_d;
      div_q        <= div_d;
      div_cnt_q    <= div_cnt_d;
      const_q      <= const_d;
      step_q       <= step_d;
      ramp_q       <= ramp_d;
      burst_q      <= burst_d;
      lfsr_q       <= lfsr_d;
      sample_cnt_q <= sample_cnt_d;
      low_seen_q   <= low_seen_d;
      frame_q      <= frame_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      data_q       <= data_d;
    end
  end

  assign bus.frame_o      = frame_q;
  assign bus.valid_o      = frame_q;
  assign bus.data_o       = data_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.sample_cnt_o = sample_cnt_q;

endmodule

// File: tb/tb_fmc_adc_pattern_gen.sv
// Self-checking bench for fmc_adc_pattern_gen: run-level behavioural model compared every
// cycle, plus directed scenarios with hand-computed channel values and timings.
module tb_fmc_adc_pattern_gen;

  localparam int NCH = 4;
  localparam int DW  = 14;
  localparam int FDW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fmc_adc_pattern_gen_if #(.g_NB_CHANNELS(NCH), .g_DATA_WIDTH(DW), .g_FRAME_DIV_WIDTH(FDW)) bus ();

  fmc_adc_pattern_gen #(.g_NB_CHANNELS(NCH), .g_DATA_WIDTH(DW), .g_FRAME_DIV_WIDTH(FDW)) dut (
    .clk_sys_i (clk),
    .rst_sys_i (rst),
    .bus       (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Samples are placed by elapsed time since the start edge; data is the closed-form formula of n.
  int              m_state = 0;  // 0 idle, 1 running, 2 burst finished
  bit              m_low   = 1'b1;
  int              m_t, m_n, m_div;
  logic [1:0]      m_mode;
  logic [DW-1:0]   m_const, m_step;
  logic [15:0]     m_burst;
  logic            e_frame = 1'b0, e_busy = 1'b0, e_done = 1'b0;
  logic [15:0]     e_cnt   = '0;
  logic [NCH*DW-1:0] e_data = '0;

  function automatic logic [NCH*DW-1:0] model_data(input int n);
    logic [NCH*DW-1:0] d;
    logic [15:0]       l;
    logic [DW-1:0]     v;
    d = '0;
    l = 16'hACE1;
    for (int i = 0; i < n; i++) l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    for (int k = 0; k < NCH; k++) begin
      case (m_mode)
        2'b00:   v = m_const;
        2'b01:   v = DW'(int'(m_const) + k + n * int'(m_step));
        2'b10:   v = l[DW-1:0] ^ DW'(k);
        default: v = ((n % 2) == 1) ? ~m_const : m_const;
      endcase
      d[k*DW +: DW] = v;
    end
    return d;
  endfunction

  task automatic model_try_emit();
    if ((m_t % (m_div + 1)) == m_div) begin
      e_data  = model_data(m_n);
      m_n++;
      e_cnt   = e_cnt + 16'd1;
      e_frame = 1'b1;
      if (m_burst != 16'd0 && e_cnt == m_burst) m_state = 2;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_low = 1'b1;
      e_frame = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_cnt = '0; e_data = '0;
    end else begin
      e_frame = 1'b0;
      e_done  = 1'b0;
      case (m_state)
        0: begin
          if (!bus.enable_i) m_low = 1'b1;
          else if (m_low) begin
            m_mode = bus.mode_i; m_div = int'(bus.frame_div_i); m_const = bus.const_i;
            m_step = bus.ramp_step_i; m_burst = bus.burst_len_i;
            m_t = 0; m_n = 0; e_cnt = '0; e_busy = 1'b1; m_low = 1'b0; m_state = 1;
            model_try_emit();
          end
        end
        1: begin
          if (!bus.enable_i) begin
            m_state = 0; e_busy = 1'b0; m_low = 1'b1;
          end else begin
            m_t++;
            model_try_emit();
          end
        end
        default: begin
          m_state = 0; e_busy = 1'b0; e_done = 1'b1;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("frame_o",      {63'd0, bus.frame_o}, {63'd0, e_frame});
      check("valid_o",      {63'd0, bus.valid_o}, {63'd0, e_frame});
      check("busy_o",       {63'd0, bus.busy_o},  {63'd0, e_busy});
      check("done_o",       {63'd0, bus.done_o},  {63'd0, e_done});
      check("sample_cnt_o", {48'd0, bus.sample_cnt_o}, {48'd0, e_cnt});
      check("data_o",       {8'd0, bus.data_o}, {8'd0, e_data});
    end
  end

  // ---------------- capture of samples for directed checks ----------------
  int            cap_cyc[$];
  logic [DW-1:0] cap0[$], cap1[$], cap3[$];
  int            done_cyc[$];

  always @(negedge clk) begin
    if (bus.valid_o === 1'b1) begin
      cap_cyc.push_back(cyc);
      cap0.push_back(bus.data_o[0*DW +: DW]);
      cap1.push_back(bus.data_o[1*DW +: DW]);
      cap3.push_back(bus.data_o[3*DW +: DW]);
    end
    if (bus.done_o === 1'b1) done_cyc.push_back(cyc);
  end

  task automatic start_run(input logic [1:0] mode, input int div, input logic [DW-1:0] c,
                           input logic [DW-1:0] step, input logic [15:0] burst, output int n0);
    @(negedge clk);
    bus.mode_i      = mode;
    bus.frame_div_i = FDW'(div);
    bus.const_i     = c;
    bus.ramp_step_i = step;
    bus.burst_len_i = burst;
    bus.enable_i    = 1'b1;
    n0 = cyc;
  endtask

  task automatic stop_run();
    @(negedge clk);
    bus.enable_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_caps(input int target, input int limit, input string name);
    int n = 0;
    while (cap_cyc.size() < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({name, "_timeout"}, {63'd0, cap_cyc.size() >= target}, 64'd1);
  endtask

  int n0, base, dbase;

  initial begin
    bus.enable_i = 1'b0; bus.mode_i = 2'b00; bus.frame_div_i = '0;
    bus.const_i = '0; bus.ramp_step_i = '0; bus.burst_len_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    check("rst_busy",  {63'd0, bus.busy_o}, 64'd0);
    check("rst_valid", {63'd0, bus.valid_o}, 64'd0);
    check("rst_data",  {8'd0, bus.data_o}, 64'd0);
    check("rst_cnt",   {48'd0, bus.sample_cnt_o}, 64'd0);
    repeat (2) @(negedge clk);

    // Ramp, div 3, continuous
    base = cap_cyc.size();
    start_run(2'b01, 3, 14'h0, 14'h1, 16'd0, n0);
    wait_caps(base + 3, 40, "ramp");
    check("ramp_first_lat", 64'(cap_cyc[base] - n0), 64'd4);
    check("ramp_period",    64'(cap_cyc[base+1] - cap_cyc[base]), 64'd4);
    check("ramp_ch0_0", {50'd0, cap0[base]},   64'd0);
    check("ramp_ch0_1", {50'd0, cap0[base+1]}, 64'd1);
    check("ramp_ch0_2", {50'd0, cap0[base+2]}, 64'd2);
    check("ramp_ch3_0", {50'd0, cap3[base]},   64'd3);
    check("ramp_ch3_1", {50'd0, cap3[base+1]}, 64'd4);
    check("ramp_ch3_2", {50'd0, cap3[base+2]}, 64'd5);
    stop_run();

    // Ramp wrap, div 0
    base = cap_cyc.size();
    start_run(2'b01, 0, 14'h3FFE, 14'h1, 16'd0, n0);
    wait_caps(base + 3, 20, "wrap");
    check("wrap_ch0_0", {50'd0, cap0[base]},   64'h3FFE);
    check("wrap_ch0_1", {50'd0, cap0[base+1]}, 64'h3FFF);
    check("wrap_ch0_2", {50'd0, cap0[base+2]}, 64'h0000);
    stop_run();

    // LFSR, div 0
    base = cap_cyc.size();
    start_run(2'b10, 0, 14'h0, 14'h0, 16'd0, n0);
    wait_caps(base + 2, 20, "lfsr");
    check("lfsr_ch0_0", {50'd0, cap0[base]},   64'h2CE1);
    check("lfsr_ch0_1", {50'd0, cap0[base+1]}, 64'h2270);
    check("lfsr_ch1_0", {50'd0, cap1[base]},   64'h2CE0);
    check("lfsr_ch1_1", {50'd0, cap1[base+1]}, 64'h2271);
    stop_run();

    // Alternating burst of 5, enable held high afterwards
    base = cap_cyc.size();
    dbase = done_cyc.size();
    start_run(2'b11, 1, 14'h1555, 14'h0, 16'd5, n0);
    repeat (30) @(negedge clk);
    check("burst_count", 64'(cap_cyc.size() - base), 64'd5);
    check("burst_ch0_0", {50'd0, cap0[base]},   64'h1555);
    check("burst_ch0_1", {50'd0, cap0[base+1]}, 64'h2AAA);
    check("burst_ch0_2", {50'd0, cap0[base+2]}, 64'h1555);
    check("burst_ch0_3", {50'd0, cap0[base+3]}, 64'h2AAA);
    check("burst_ch0_4", {50'd0, cap0[base+4]}, 64'h1555);
    check("burst_done_count", 64'(done_cyc.size() - dbase), 64'd1);
    check("burst_done_lat", 64'(done_cyc[dbase] - cap_cyc[base+4]), 64'd1);
    check("burst_cnt", {48'd0, bus.sample_cnt_o}, 64'd5);

    // Back-to-back: one low cycle, then a constant-mode burst of 3
    @(negedge clk);
    bus.enable_i = 1'b0;
    base = cap_cyc.size();
    start_run(2'b00, 2, 14'h0ABC, 14'h0, 16'd3, n0);
    repeat (20) @(negedge clk);
    check("b2b_count", 64'(cap_cyc.size() - base), 64'd3);
    check("b2b_ch3",   {50'd0, cap3[base+2]}, 64'h0ABC);
    check("b2b_cnt",   {48'd0, bus.sample_cnt_o}, 64'd3);
    stop_run();

    // Abort after two samples
    base = cap_cyc.size();
    dbase = done_cyc.size();
    start_run(2'b01, 3, 14'h5, 14'h2, 16'd0, n0);
    wait_caps(base + 2, 30, "abort");
    bus.enable_i = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_cnt",   {48'd0, bus.sample_cnt_o}, 64'd2);
    check("abort_busy",  {63'd0, bus.busy_o}, 64'd0);
    check("abort_done",  64'(done_cyc.size() - dbase), 64'd0);
    check("abort_count", 64'(cap_cyc.size() - base), 64'd2);
    check("abort_hold",  {50'd0, bus.data_o[3*DW +: DW]}, 64'd10);
    repeat (2) @(negedge clk);

    // frame_div_i changed mid-burst has no effect until the next run
    base = cap_cyc.size();
    start_run(2'b01, 3, 14'h0, 14'h1, 16'd6, n0);
    wait_caps(base + 2, 30, "divchg");
    bus.frame_div_i = 4'd7;
    bus.const_i     = 14'h1234;
    repeat (30) @(negedge clk);
    check("divchg_count",   64'(cap_cyc.size() - base), 64'd6);
    check("divchg_period",  64'(cap_cyc[base+5] - cap_cyc[base+4]), 64'd4);
    check("divchg_ch0_5",   {50'd0, cap0[base+5]}, 64'd5);
    @(negedge clk);
    bus.enable_i = 1'b0;
    base = cap_cyc.size();
    start_run(2'b01, 7, 14'h0, 14'h1, 16'd2, n0);
    repeat (25) @(negedge clk);
    check("div7_first_lat", 64'(cap_cyc[base] - n0), 64'd8);
    check("div7_period",    64'(cap_cyc[base+1] - cap_cyc[base]), 64'd8);
    stop_run();

    // Reset in the middle of a run
    start_run(2'b01, 0, 14'h100, 14'h3, 16'd0, n0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy",  {63'd0, bus.busy_o}, 64'd0);
    check("mrst_valid", {63'd0, bus.valid_o}, 64'd0);
    check("mrst_done",  {63'd0, bus.done_o}, 64'd0);
    check("mrst_data",  {8'd0, bus.data_o}, 64'd0);
    check("mrst_cnt",   {48'd0, bus.sample_cnt_o}, 64'd0);
    bus.enable_i = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
